// File: rtl/fpu_pkg.sv
// fpu_pkg - shared definitions for the sequential FPU divider.
//   div_state_t : divider FSM states {IDLE, DIV, NORM, DONE}
//   BIAS, QNAN_32, INF_32, ZERO_32 : default binary32 constants
//   bias_of / exp_ones / is_nan / is_inf / is_zero : width-parametrised helpers.
//   Exponent and fraction fields are passed zero-extended to MAX_EXP_W / MAX_MAN_W bits.
package fpu_pkg;

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} div_state_t;

    localparam int MAX_EXP_W = 16;
    localparam int MAX_MAN_W = 64;

    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN_32 = 32'h7FC0_0000;
    localparam logic [31:0] INF_32  = 32'h7F80_0000;
    localparam logic [31:0] ZERO_32 = 32'h0000_0000;

    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic [MAX_EXP_W-1:0] exp_ones(input int exp_w);
        return MAX_EXP_W'((1 << exp_w) - 1);
    endfunction

    function automatic logic is_nan(input logic [MAX_EXP_W-1:0] e,
                                    input logic [MAX_MAN_W-1:0] f,
                                    input int exp_w);
        return (e == exp_ones(exp_w)) && (f != '0);
    endfunction

    function automatic logic is_inf(input logic [MAX_EXP_W-1:0] e,
                                    input logic [MAX_MAN_W-1:0] f,
                                    input int exp_w);
        return (e == exp_ones(exp_w)) && (f == '0);
    endfunction

    // Denormals count as zero: inputs are flushed to signed zero.
    function automatic logic is_zero(input logic [MAX_EXP_W-1:0] e);
        return e == '0;
    endfunction

endpackage

// File: rtl/fpu_div_mant_iter.sv
// fpu_div_mant_iter - radix-2 restoring mantissa divider, one quotient bit per enable.
//   load      : start a new division with dividend/divisor (both 1.f, hidden bit set)
//   en        : perform one step (compare, subtract, shift)
//   quo       : quotient bits, MSB has weight 2^0
//   rem_nz    : partial remainder is non-zero (sticky source)
//   last_step : the step taken on this enable is the final (MAN_W+3)th one
module fpu_div_mant_iter
    import fpu_pkg::*;
#(
    parameter int MAN_W = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [MAN_W:0]   dividend,
    input  logic [MAN_W:0]   divisor,
    output logic [MAN_W+2:0] quo,
    output logic             rem_nz,
    output logic             last_step
);

    localparam int QW = MAN_W + 3;
    localparam int CW = $clog2(QW + 1);

    // Remainder stays below 2*divisor, so two spare bits above the mantissa suffice.
    logic [QW-1:0] rem;
    logic [MAN_W:0] dvs;
    logic [CW-1:0] cnt;
    logic [QW-1:0] dvs_ext;
    logic          ge;
    logic [QW-1:0] rem_next;

    always_comb begin
        dvs_ext  = {2'b00, dvs};
        ge       = (rem >= dvs_ext);
        rem_next = ge ? (rem - dvs_ext) : rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            dvs <= '0;
            quo <= '0;
            cnt <= '0;
        end else if (load) begin
            rem <= {2'b00, dividend};
            dvs <= divisor;
            quo <= '0;
            cnt <= '0;
        end else if (en) begin
            rem <= rem_next << 1;
            quo <= {quo[QW-2:0], ge};
            cnt <= cnt + CW'(1);
        end
    end

    assign last_step = (cnt == CW'(QW - 1));
    assign rem_nz    = |rem;

endmodule

// File: rtl/fpu_seq_divider.sv
// fpu_seq_divider - multi-cycle IEEE-754 divider (A / B), one operation in flight.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake; in_ready is high only in IDLE
//   A, B              : dividend, divisor (captured on accept)
//   out_valid/out_ready : result handshake; result and flags hold until accepted
//   result            : quotient
//   overflow, underflow, div_by_zero, invalid : exception flags
// Handshake: a transfer happens on a rising edge where valid && ready are both high;
// the producer holds its data stable while valid is high and ready is low.
// Build option: FPU_DIV_RNE_EN selects round-to-nearest-even; otherwise truncate.
module fpu_seq_divider
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int WIDTH = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             underflow,
    output logic             div_by_zero,
    output logic             invalid
);

    localparam int EW = EXP_W + 2;
    localparam int QW = MAN_W + 3;
    localparam logic signed [EW-1:0] BIAS_S = EW'(bias_of(EXP_W));
    localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic signed [EW-1:0] ZERO_S = EW'(0);
    localparam logic [WIDTH-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FPU_DIV_RNE_EN
    localparam logic RNE_EN = 1'b1;
`else
    localparam logic RNE_EN = 1'b0;
`endif

    div_state_t state;

    // Operand unpack and special-case detection (combinational on the inputs).
    logic             sign_a, sign_b, sign_q;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] frac_a, frac_b;
    logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic             spec_hit, spec_inv, spec_dbz;
    logic [WIDTH-1:0] spec_res;
    logic signed [EW-1:0] exp_in;

    assign {sign_a, exp_a, frac_a} = A;
    assign {sign_b, exp_b, frac_b} = B;

    always_comb begin
        sign_q = sign_a ^ sign_b;
        nan_a  = is_nan(MAX_EXP_W'(exp_a), MAX_MAN_W'(frac_a), EXP_W);
        nan_b  = is_nan(MAX_EXP_W'(exp_b), MAX_MAN_W'(frac_b), EXP_W);
        inf_a  = is_inf(MAX_EXP_W'(exp_a), MAX_MAN_W'(frac_a), EXP_W);
        inf_b  = is_inf(MAX_EXP_W'(exp_b), MAX_MAN_W'(frac_b), EXP_W);
        zero_a = is_zero(MAX_EXP_W'(exp_a));
        zero_b = is_zero(MAX_EXP_W'(exp_b));
        exp_in = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS_S;

        spec_hit = 1'b1;
        spec_inv = 1'b0;
        spec_dbz = 1'b0;
        spec_res = '0;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if (inf_a) begin
            spec_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero_b) begin
            spec_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_dbz = 1'b1;
        end else if (zero_a || inf_b) begin
            spec_res = {sign_q, {(WIDTH-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Mantissa division.
    logic          iter_load, iter_en, iter_last, rem_nz;
    logic [QW-1:0] quo;

    assign in_ready  = (state == IDLE);
    assign iter_load = in_ready && in_valid && !spec_hit;
    assign iter_en   = (state == DIV);

    fpu_div_mant_iter #(.MAN_W(MAN_W)) u_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (iter_load),
        .en        (iter_en),
        .dividend  ({1'b1, frac_a}),
        .divisor   ({1'b1, frac_b}),
        .quo       (quo),
        .rem_nz    (rem_nz),
        .last_step (iter_last)
    );

    // Normalise, round, range-check and pack.
    logic                 sign_r;
    logic signed [EW-1:0] exp_r, e_n, e_f;
    logic                 q_hi, guard, sticky, round_up, carry, ovf, unf;
    logic [MAN_W:0]       mant;
    logic [MAN_W+1:0]     mant_r;
    logic [WIDTH-1:0]     norm_res;

    always_comb begin
        // Quotient lies in (0.5, 2): a clear top bit means shift left by one.
        q_hi     = quo[QW-1];
        mant     = q_hi ? quo[QW-1:2] : quo[QW-2:1];
        guard    = q_hi ? quo[1] : quo[0];
        sticky   = q_hi ? (quo[0] | rem_nz) : rem_nz;
        e_n      = q_hi ? exp_r : (exp_r - ONE_S);
        round_up = RNE_EN & guard & (sticky | mant[0]);
        mant_r   = {1'b0, mant} + {{(MAN_W+1){1'b0}}, round_up};
        // Rounding 1.11..1 up gives 10.00..0: fraction is already zero, bump exponent.
        carry    = (mant_r[MAN_W+1:MAN_W] == 2'b10);
        e_f      = e_n + (carry ? ONE_S : ZERO_S);
        ovf      = (e_f >= EMAX_S);
        unf      = !ovf && (e_f <= ZERO_S);
        if (ovf)
            norm_res = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (unf)
            norm_res = {sign_r, {(WIDTH-1){1'b0}}};
        else
            norm_res = {sign_r, e_f[EXP_W-1:0], mant_r[MAN_W-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            result      <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
            sign_r      <= 1'b0;
            exp_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= sign_q;
                        exp_r  <= exp_in;
                        if (spec_hit) begin
                            result      <= spec_res;
                            invalid     <= spec_inv;
                            div_by_zero <= spec_dbz;
                            overflow    <= 1'b0;
                            underflow   <= 1'b0;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (iter_last) state <= NORM;
                end
                NORM: begin
                    result      <= norm_res;
                    overflow    <= ovf;
                    underflow   <= unf;
                    invalid     <= 1'b0;
                    div_by_zero <= 1'b0;
                    out_valid   <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_seq_divider.sv
// tb_fpu_seq_divider - randomized and directed bench for fpu_seq_divider (binary32).
// Expected results come from an exact integer-division reference model.
module tb_fpu_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] A, B, result;
    logic        overflow, underflow, div_by_zero, invalid;

    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q[$];

`ifdef FPU_DIV_RNE_EN
    localparam logic [31:0] THIRD = 32'h3EAA_AAAB;
    localparam bit MODEL_RNE = 1'b1;
`else
    localparam logic [31:0] THIRD = 32'h3EAA_AAAA;
    localparam bit MODEL_RNE = 1'b0;
`endif

    fpu_seq_divider dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero),
        .invalid     (invalid)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: returns {invalid, div_by_zero, overflow, underflow, result}.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, e, low;
        bit sa, sb, s, za, zb, ia, ib, na, nb;
        longint unsigned ma, mb, num, qq, rr, mant;
        sa = a[31]; sb = b[31]; s = sa ^ sb;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0); ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0); nb = (eb == 255) && (b[22:0] != 0);
        if (na || nb || (za && zb) || (ia && ib)) return {4'b1000, 32'h7FC0_0000};
        if (ia) return {4'b0000, s, 31'h7F80_0000};
        if (zb) return {4'b0100, s, 31'h7F80_0000};
        if (za || ib) return {4'b0000, s, 31'h0};
        ma = 64'(a[22:0]) + 64'h80_0000;
        mb = 64'(b[22:0]) + 64'h80_0000;
        e = ea - eb + 127;
        // Scale so the integer quotient lies in [2^30, 2^31): 24 kept bits + 7 below.
        if (ma < mb) begin
            num = ma << 31;
            e = e - 1;
        end else begin
            num = ma << 30;
        end
        qq = num / mb;
        rr = num % mb;
        mant = qq >> 7;
        low = int'(qq & 64'd127);
        if (MODEL_RNE && (low > 64 || (low == 64 && (rr != 0 || mant[0])))) mant = mant + 1;
        if (mant == 64'h100_0000) begin
            mant = 64'h80_0000;
            e = e + 1;
        end
        if (e >= 255) return {4'b0010, s, 31'h7F80_0000};
        if (e <= 0) return {4'b0001, s, 31'h0};
        return {4'b0000, s, 8'(e), mant[22:0]};
    endfunction

    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
               (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
    endfunction

    function automatic logic [31:0] rand_op();
        int k;
        logic [7:0] e;
        logic [22:0] f;
        k = $urandom_range(0, 19);
        f = 23'($urandom);
        if (k == 0) e = 8'h00;
        else if (k == 1) begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = '0; end
        else if (k <= 3) e = 8'($urandom_range(1, 12));
        else if (k <= 5) e = 8'($urandom_range(243, 254));
        else e = 8'($urandom_range(100, 154));
        if ($urandom_range(0, 7) == 0) f = '1;
        return {1'($urandom), e, f};
    endfunction

    // Driver: issue one operation, check latency/result/flags, hold off out_ready, release.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                          input bit use_const, input logic [35:0] const_exp);
        logic [35:0] exp_v;
        int lat;
        bit seen;
        lat = 0;
        while (!in_ready && lat < 100) begin @(negedge clk); lat++; end
        check_eq("in_ready_before", 64'(in_ready), 64'd1);
        A = a; B = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = $urandom; B = $urandom;
        exp_q.push_back(model(a, b));
        lat = 0; seen = 1'b0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            seen = out_valid;
        end
        check_eq("latency", 64'(lat), is_special(a, b) ? 64'd1 : 64'd28);
        exp_v = exp_q.pop_front();
        check_eq("result", 64'(result), 64'(exp_v[31:0]));
        check_eq("flags", 64'({invalid, div_by_zero, overflow, underflow}), 64'(exp_v[35:32]));
        if (use_const) begin
            check_eq("vector_result", 64'(result), 64'(const_exp[31:0]));
            check_eq("vector_flags", 64'({invalid, div_by_zero, overflow, underflow}),
                     64'(const_exp[35:32]));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
            check_eq("hold_data", 64'({invalid, div_by_zero, overflow, underflow, result}),
                     64'(exp_v));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("in_ready_after", 64'(in_ready), 64'd1);
        check_eq("out_valid_after", 64'(out_valid), 64'd0);
    endtask

    initial begin
        bit spurious;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_flags", 64'({invalid, div_by_zero, overflow, underflow}), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        run_op(32'h40C0_0000, 32'h4000_0000, 20, 1'b1, {4'b0000, 32'h4040_0000});
        run_op(32'h3F80_0000, 32'h4040_0000, 0, 1'b1, {4'b0000, THIRD});
        run_op(32'h3F80_0000, 32'h0000_0000, 2, 1'b1, {4'b0100, 32'h7F80_0000});
        run_op(32'h0000_0000, 32'h0000_0000, 1, 1'b1, {4'b1000, 32'h7FC0_0000});
        run_op(32'h7F00_0000, 32'h0080_0000, 0, 1'b1, {4'b0010, 32'h7F80_0000});
        run_op(32'h0080_0000, 32'h4000_0000, 0, 1'b1, {4'b0001, 32'h0000_0000});

        // Reset during DIV aborts the operation
        A = 32'h40C0_0000; B = 32'h4000_0000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_in_ready", 64'(in_ready), 64'd1);
        check_eq("abort_out_valid", 64'(out_valid), 64'd0);
        check_eq("abort_result", 64'(result), 64'd0);
        spurious = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) spurious = 1'b1;
        end
        check_eq("abort_no_output", 64'(spurious), 64'd0);
        run_op(32'h40C0_0000, 32'h4000_0000, 0, 1'b1, {4'b0000, 32'h4040_0000});

        // Randomized operations
        for (int n = 0; n < 60; n++) begin
            run_op(rand_op(), rand_op(), $urandom_range(0, 3), 1'b0, 36'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
